// File: rtl/vc_arbiter.sv
// vc_arbiter: moves words from four source FIFOs into one destination FIFO and configures FIFO thresholds.
// Build option PRIORITY_RR_EN: round-robin grant; left undefined, fixed priority with source 0 highest.
//
// state  | meaning
// RESET  | held by reset, outputs cleared
// INIT   | loading alto/bajo thresholds while init=1
// IDLE   | no work pending, waiting for a non-empty source
// ACTIVE | granting pops and forwarding words to the destination

module vc_arbiter #(
    parameter int DATA_WIDTH = 10,
    parameter int THR_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [THR_WIDTH-1:0]    umbral_alto_in,
    input  logic [THR_WIDTH-1:0]    umbral_bajo_in,
    input  logic [3:0]              src_empty,
    input  logic [3:0]              src_almost_empty,
    input  logic [4*DATA_WIDTH-1:0] src_data,
    input  logic                    dst_full,
    input  logic                    dst_almost_full,
    output logic [3:0]              src_pop,
    output logic                    dst_push,
    output logic [DATA_WIDTH-1:0]   dst_data,
    output logic [THR_WIDTH-1:0]    alto_out,
    output logic [THR_WIDTH-1:0]    bajo_out,
    output logic [3:0]              state,
    output logic                    idle_out,
    output logic [7:0]              transfer_cnt
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [3:0]            eligible;
    logic [3:0]            grant_d;
    logic                  pop_allowed;
    logic [DATA_WIDTH-1:0] pop_word;
    logic                  cnt_clear;

    assign state    = state_q;
    assign idle_out = (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (init)                                      state_d = ST_INIT;
                else if (!(&src_empty) && !dst_almost_full)    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                      state_d = ST_INIT;
                else if ((&src_empty) && (src_pop == 4'b0000)) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    // A source that is almost empty and was just popped may already be drained; skip it once.
    assign eligible    = ~src_empty & ~(src_almost_empty & src_pop);
    assign pop_allowed = (state_q == ST_ACTIVE) && !init && !dst_full && !dst_almost_full;

`ifdef PRIORITY_RR_EN
    logic [1:0] rr_ptr_q;
    logic [1:0] grant_idx;
    logic [1:0] cand;
    logic       found;

    always_comb begin
        grant_d   = 4'b0000;
        grant_idx = rr_ptr_q;
        cand      = rr_ptr_q;
        found     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!found && eligible[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (pop_allowed && found) grant_d[grant_idx] = 1'b1;
    end

    // rr_ptr_q holds where the next search starts: one past the last granted source.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q <= 2'd0;
        end else if (state_d == ST_INIT) begin
            rr_ptr_q <= 2'd0;
        end else if (grant_d != 4'b0000) begin
            rr_ptr_q <= grant_idx + 2'd1;
        end
    end
`else
    always_comb begin
        grant_d = 4'b0000;
        if (pop_allowed) begin
            if (eligible[0])      grant_d = 4'b0001;
            else if (eligible[1]) grant_d = 4'b0010;
            else if (eligible[2]) grant_d = 4'b0100;
            else if (eligible[3]) grant_d = 4'b1000;
        end
    end
`endif

    always_comb begin
        pop_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (src_pop[i]) pop_word = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pushes that complete while in INIT are not counted toward the new session.
    assign cnt_clear = (state_d == ST_INIT) || (state_q == ST_INIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            src_pop      <= 4'b0000;
            dst_push     <= 1'b0;
            dst_data     <= '0;
            alto_out     <= '0;
            bajo_out     <= '0;
            transfer_cnt <= 8'd0;
        end else begin
            src_pop  <= grant_d;
            dst_push <= |src_pop;
            dst_data <= pop_word;
            if ((state_q == ST_INIT) && init) begin
                alto_out <= umbral_alto_in;
                bajo_out <= umbral_bajo_in;
            end
            if (cnt_clear) begin
                transfer_cnt <= 8'd0;
            end else if (dst_push && (transfer_cnt != 8'hFF)) begin
                transfer_cnt <= transfer_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: source FIFOs modelled as queues, pushed words checked in order against a scoreboard.
// Expected grant order follows PRIORITY_RR_EN when the bench is built with it.

module tb_vc_arbiter;

    localparam int DW = 10;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            init;
    logic [TW-1:0]   umbral_alto_in;
    logic [TW-1:0]   umbral_bajo_in;
    logic [3:0]      src_empty;
    logic [3:0]      src_almost_empty;
    logic [4*DW-1:0] src_data;
    logic            dst_full;
    logic            dst_almost_full;
    logic [3:0]      src_pop;
    logic            dst_push;
    logic [DW-1:0]   dst_data;
    logic [TW-1:0]   alto_out;
    logic [TW-1:0]   bajo_out;
    logic [3:0]      state;
    logic            idle_out;
    logic [7:0]      transfer_cnt;

    logic [DW-1:0]   fq [4][$];
    logic [DW-1:0]   sb [$];
    logic [3:0]      pop_log [$];
    logic [3:0]      pop_obs;
    logic [3:0]      ae_force;
    int              n_total = 0;
    int              n_pass  = 0;

    vc_arbiter #(.DATA_WIDTH(DW), .THR_WIDTH(TW)) dut (
        .clk              (clk),
        .reset            (reset),
        .init             (init),
        .umbral_alto_in   (umbral_alto_in),
        .umbral_bajo_in   (umbral_bajo_in),
        .src_empty        (src_empty),
        .src_almost_empty (src_almost_empty),
        .src_data         (src_data),
        .dst_full         (dst_full),
        .dst_almost_full  (dst_almost_full),
        .src_pop          (src_pop),
        .dst_push         (dst_push),
        .dst_data         (dst_data),
        .alto_out         (alto_out),
        .bajo_out         (bajo_out),
        .state            (state),
        .idle_out         (idle_out),
        .transfer_cnt     (transfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic update_flags();
        for (int i = 0; i < 4; i++) begin
            src_empty[i]        = (fq[i].size() == 0);
            src_almost_empty[i] = (fq[i].size() <= 1) || ae_force[i];
            src_data[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    task automatic load(input int s, input int n);
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = DW'($urandom);
            fq[s].push_back(w);
        end
        update_flags();
    endtask

    // One clock: source FIFOs consume the pop that was live at the edge, then outputs are sampled.
    task automatic cycle();
        logic [DW-1:0] exp_w;
        @(posedge clk);
        #1;
        if (!reset) sb.delete();
        for (int i = 0; i < 4; i++) begin
            if (pop_obs[i]) begin
                if (fq[i].size() == 0) chk("pop_of_empty", 32'(fq[i].size()), 32'd1);
                else void'(fq[i].pop_front());
            end
        end
        update_flags();
        @(negedge clk);
        pop_obs = src_pop;
        pop_log.push_back(src_pop);
        if (dst_push) begin
            if (sb.size() == 0) begin
                chk("push_without_pop", 32'(sb.size()), 32'd1);
            end else begin
                exp_w = sb.pop_front();
                chk("dst_data", 32'(dst_data), 32'(exp_w));
            end
        end else begin
            chk("data_idle", 32'(dst_data), 32'd0);
        end
        if (src_pop != 4'b0000) begin
            chk("pop_onehot", 32'($countones(src_pop)), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (src_pop[i]) sb.push_back((fq[i].size() != 0) ? fq[i][0] : '0);
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while ((state != 4'b0100) && (k < max));
        chk("reach_idle", 32'(state), 32'h4);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_pop(input int max);
        int k;
        k = 0;
        while ((src_pop == 4'b0000) && (k < max)) begin
            cycle();
            k++;
        end
        chk("pop_seen", 32'(src_pop != 4'b0000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [5];
        logic [3:0] exp_seq [5];
        int         j;
        int         n_pops;
        int         n_bad;
        int         consec;

`ifdef PRIORITY_RR_EN
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        reset           = 1'b0;
        init            = 1'b0;
        umbral_alto_in  = '0;
        umbral_bajo_in  = '0;
        dst_full        = 1'b0;
        dst_almost_full = 1'b0;
        ae_force        = 4'b0000;
        pop_obs         = 4'b0000;
        src_empty       = 4'b1111;
        src_almost_empty = 4'b1111;
        src_data        = '0;
        update_flags();

        // Reset and threshold load
        cycle();
        cycle();
        chk("rst_state", 32'(state), 32'h1);
        chk("rst_pop", 32'(src_pop), 32'h0);
        chk("rst_push", 32'(dst_push), 32'h0);
        chk("rst_alto", 32'(alto_out), 32'h0);
        chk("rst_bajo", 32'(bajo_out), 32'h0);
        chk("rst_idle", 32'(idle_out), 32'h0);
        chk("rst_cnt", 32'(transfer_cnt), 32'h0);
        reset          = 1'b1;
        init           = 1'b1;
        umbral_alto_in = 3'd6;
        umbral_bajo_in = 3'd1;
        cycle();
        chk("to_init", 32'(state), 32'h2);
        cycle();
        chk("alto_load", 32'(alto_out), 32'd6);
        chk("bajo_load", 32'(bajo_out), 32'd1);
        init = 1'b0;
        cycle();
        chk("to_idle", 32'(state), 32'h4);
        chk("idle_flag", 32'(idle_out), 32'h1);

        // Single source, three words
        load(0, 3);
        pop_log.delete();
        cycle();
        chk("single_active", 32'(state), 32'h8);
        chk("active_idle_flag", 32'(idle_out), 32'h0);
        run_until_idle(30);
        n_pops = 0;
        n_bad  = 0;
        foreach (pop_log[k]) begin
            if (pop_log[k] != 4'b0000) begin
                n_pops++;
                if (pop_log[k] != 4'b0001) n_bad++;
            end
        end
        chk("single_pops", 32'(n_pops), 32'd3);
        chk("single_src", 32'(n_bad), 32'd0);
        chk("single_cnt", 32'(transfer_cnt), 32'd3);

        // Re-init to clear pointer and counter, then all four sources loaded
        init = 1'b1;
        cycle();
        chk("reinit_cnt", 32'(transfer_cnt), 32'd0);
        init = 1'b0;
        cycle();
        chk("reinit_idle", 32'(state), 32'h4);
        for (int s = 0; s < 4; s++) load(s, 6);
        pop_log.delete();
        cycle();
        run_until_idle(200);
        foreach (seq[i]) seq[i] = 4'b0000;
        j = 0;
        foreach (pop_log[k]) begin
            if ((pop_log[k] != 4'b0000) && (j < 5)) begin
                seq[j] = pop_log[k];
                j++;
            end
        end
        for (int i = 0; i < 5; i++) chk($sformatf("grant_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        chk("all_cnt", 32'(transfer_cnt), 32'd24);

        // dst_almost_full right after a pop
        load(1, 5);
        cycle();
        wait_pop(10);
        dst_almost_full = 1'b1;
        cycle();
        chk("af_push_done", 32'(dst_push), 32'h1);
        chk("af_no_pop", 32'(src_pop), 32'h0);
        n_bad = 0;
        repeat (4) begin
            cycle();
            if (src_pop != 4'b0000) n_bad++;
        end
        chk("af_hold", 32'(n_bad), 32'd0);
        dst_almost_full = 1'b0;
        run_until_idle(50);
        chk("af_cnt", 32'(transfer_cnt), 32'd29);

        // Almost-empty source is never popped twice in a row
        ae_force = 4'b0100;
        load(2, 4);
        pop_log.delete();
        cycle();
        run_until_idle(60);
        n_pops = 0;
        consec = 0;
        foreach (pop_log[k]) begin
            if (pop_log[k][2]) n_pops++;
            if ((k > 0) && pop_log[k][2] && pop_log[k-1][2]) consec++;
        end
        chk("ae_pops", 32'(n_pops), 32'd4);
        chk("ae_consec", 32'(consec), 32'd0);
        ae_force = 4'b0000;
        update_flags();

        // dst_full blocks new pops
        load(0, 3);
        cycle();
        dst_full = 1'b1;
        n_bad = 0;
        repeat (3) begin
            cycle();
            if (src_pop != 4'b0000) n_bad++;
        end
        chk("full_hold", 32'(n_bad), 32'd0);
        dst_full = 1'b0;
        run_until_idle(40);
        chk("full_cnt", 32'(transfer_cnt), 32'd36);

        // init during ACTIVE with a push pending
        load(3, 6);
        cycle();
        chk("ini_active", 32'(state), 32'h8);
        wait_pop(10);
        init = 1'b1;
        cycle();
        chk("ini_state", 32'(state), 32'h2);
        chk("ini_push", 32'(dst_push), 32'h1);
        chk("ini_cnt", 32'(transfer_cnt), 32'd0);
        repeat (2) begin
            cycle();
            chk("ini_no_pop", 32'(src_pop), 32'h0);
            chk("ini_cnt_hold", 32'(transfer_cnt), 32'd0);
        end
        init = 1'b0;
        cycle();
        chk("ini_idle", 32'(state), 32'h4);
        run_until_idle(60);
        chk("ini_rest_cnt", 32'(transfer_cnt), 32'd5);

        // Counter saturation
        load(0, 260);
        cycle();
        run_until_idle(1000);
        chk("cnt_sat", 32'(transfer_cnt), 32'hFF);

        // Reset in the middle of a transfer
        load(1, 4);
        cycle();
        wait_pop(10);
        reset = 1'b0;
        cycle();
        chk("mid_rst_state", 32'(state), 32'h1);
        chk("mid_rst_pop", 32'(src_pop), 32'h0);
        chk("mid_rst_push", 32'(dst_push), 32'h0);
        chk("mid_rst_cnt", 32'(transfer_cnt), 32'h0);
        chk("mid_rst_alto", 32'(alto_out), 32'h0);
        cycle();
        chk("mid_rst_pop2", 32'(src_pop), 32'h0);
        chk("mid_rst_push2", 32'(dst_push), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
